ov7670_dvp_source: RTL
======================

Name: ov7670_dvp_source

Overview:
- Synthesizable OV7670 parallel-video (DVP) transmitter that emulates the camera's pixel output: PCLK, HREF, VSYNC and 8-bit D.
- It is the sending end of the pixel bus that OV7670_CAMERA_DRIVER receives (STROBE excluded). It feeds the capture/debayer path in bench and on-board loopback when no sensor is fitted.
- It generates raw-Bayer test frames with OV7670 VGA frame structure. Timing and image size are parameterised.

Parameters:
- H_ACTIVE, 640, active pixels (bytes) per line
- H_BLANK, 144, blank pixel ticks per line (line total = H_ACTIVE+H_BLANK)
- V_ACTIVE, 480, active lines per frame
- V_SYNC, 3, lines with VSYNC high
- V_BACK, 17, blank lines after VSYNC before first active line
- V_FRONT, 10, blank lines after last active line
- PCLK_DIV, 2, clk cycles per PCLK period; must be even and >=2

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous, active-low reset
- enable  in  1  request frame generation
- pattern_sel  in  2  0=ramp, 1=Bayer flat, 2=constant, 3=frame number
- const_val  in  8  pixel value for pattern 2 (e.g. from switches)
- PCLK  out  1  pixel clock
- HREF  out  1  line-valid
- VSYNC  out  1  frame sync, active high
- D  out  8  pixel data
- frame_cnt  out  8  completed frames, wraps 255->0
- frame_done  out  1  one-clk pulse at end of each frame's V_FRONT

Behaviour:
- Reset (async assert, sync release): PCLK=0, HREF=0, VSYNC=0, D=0, frame_cnt=0, frame_done=0, state=IDLE, all counters 0. Reset asserted mid-frame forces all of these immediately.
- Tick generator: a divider counts 0..PCLK_DIV-1 continuously after reset, in every state.
  - PCLK=0 for counts 0..PCLK_DIV/2-1, PCLK=1 for the remainder.
  - The tick occurs at count 0, i.e. PCLK falling. HREF, VSYNC and D change only on the clk edge that begins a tick, so they are stable at PCLK rising.
- FSM states: IDLE, SYNC, BACK, ACTIVE, FRONT. Only tick cycles are evaluated.
  - Line counter hcnt runs 0..H_ACTIVE+H_BLANK-1. Line counter vcnt counts lines within the current state.
- IDLE: all outputs low except PCLK. At a tick with enable=1:
  - latch pattern_sel and const_val;
  - go to SYNC, with VSYNC=1 from that tick.
  - Latency: VSYNC rises at the first tick after enable is seen high (at most PCLK_DIV clks).
- SYNC: VSYNC=1 for V_SYNC full lines, then BACK.
- BACK: V_BACK lines with all outputs low, then ACTIVE.
- ACTIVE: V_ACTIVE lines.
  - HREF=1 and D=pixel(x=hcnt, y=vcnt) for hcnt<H_ACTIVE.
  - HREF=0 and D=0 during H_BLANK.
- FRONT: V_FRONT lines with outputs low. On the clk of the last FRONT tick:
  - frame_done=1 for that clk;
  - frame_cnt increments (8-bit wrap).
  - Next state is SYNC if enable=1 (pattern re-latched), else IDLE.
- enable/pattern_sel/const_val changes mid-frame are ignored until the frame boundary. Deasserting enable completes the current frame.
- Patterns (x, y truncated to 8 bits, sums mod 256):
  - 0: D = x + y
  - 1: BGGR mosaic. Even y: B=0x10 at even x, G=0x80 at odd x. Odd y: G=0x80 at even x, R=0xF0 at odd x.
  - 2: D = latched const_val
  - 3: D = frame_cnt value latched at frame start
- Width rules: hcnt/vcnt widths via $clog2 of their maxima. No counter exceeds its terminal count.
- Degenerate parameters: V_BACK=0 or V_FRONT=0 skips that state in zero lines; H_BLANK>=1 is required.

Decomposition:
- Package ov7670_pkg holds:
  - state enum (IDLE, SYNC, BACK, ACTIVE, FRONT);
  - pattern_sel codes PAT_RAMP/PAT_BAYER/PAT_CONST/PAT_FRAME;
  - Bayer constants BAYER_R=8'hF0, BAYER_G=8'h80, BAYER_B=8'h10;
  - VGA timing defaults.
- One sub-module: ov7670_pclk_gen (divider producing PCLK and the tick strobe).

Test Plan (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_SYNC=1, V_BACK=1, V_FRONT=1, PCLK_DIV=2 unless noted):
- Reset released, enable=0 -> PCLK toggles every clk; HREF, VSYNC, D, frame_cnt all 0 indefinitely.
- enable=1, pattern 0 -> VSYNC high 6 ticks, 6 low ticks, then D=00,01,02,03 with HREF=1, 2 blank ticks, then 01,02,03,04. After 6 FRONT ticks: frame_done pulse, frame_cnt=1.
- Pattern 1 -> row0 D=10,80,10,80; row1 D=80,F0,80,F0.
- Pattern 2 with const_val=A5, const_val changed to 3C mid-frame -> all active bytes A5; next frame 3C.
- enable dropped during ACTIVE line 0 -> frame completes (8 HREF bytes), frame_done pulses once, then IDLE with outputs low.
- reset_ asserted mid-ACTIVE -> all outputs 0 in the same cycle. Separately, 256 frames -> frame_cnt wraps to 0, and pattern 3 then shows 00.

Source files
------------

// File: rtl/ov7670_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ov7670_pkg                                                   |
// | Description : Shared types, pattern codes, Bayer levels and VGA timing     |
// |               defaults for the OV7670 DVP source.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        BACK   = 3'd2,
        ACTIVE = 3'd3,
        FRONT  = 3'd4
    } state_t;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BAYER = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_FRAME = 2'd3;

    localparam logic [7:0] BAYER_R = 8'hF0;
    localparam logic [7:0] BAYER_G = 8'h80;
    localparam logic [7:0] BAYER_B = 8'h10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_PCLK_DIV = 2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] pixel_value(
        input logic [1:0] pat,
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [7:0] cval,
        input logic [7:0] fnum
    );
        logic [7:0] v;
        v = 8'h00;
        case (pat)
            PAT_RAMP:  v = x + y;
            PAT_BAYER: begin
                // BGGR: even rows are B/G, odd rows are G/R
                if (!y[0]) v = x[0] ? BAYER_G : BAYER_B;
                else       v = x[0] ? BAYER_R : BAYER_G;
            end
            PAT_CONST: v = cval;
            default:   v = fnum;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_dvp_source_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ov7670_dvp_source_if                                         |
// | Description : OV7670 parallel pixel bus (PCLK, HREF, VSYNC, D).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ov7670_dvp_source_if;
    logic       PCLK;
    logic       HREF;
    logic       VSYNC;
    logic [7:0] D;

    modport master (output PCLK, HREF, VSYNC, D);
    modport slave  (input  PCLK, HREF, VSYNC, D);
endinterface
`default_nettype wire

// File: rtl/ov7670_pclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ov7670_pclk_gen                                              |
// | Description : Free-running divider producing PCLK and the pixel tick.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ov7670_pclk_gen
    import ov7670_pkg::*;
#(
    parameter int PCLK_DIV = DEF_PCLK_DIV
) (
    input  logic clk,
    input  logic reset_,
    output logic o_pclk,
    output logic o_tick
);

    localparam int              c_DW       = cnt_width(PCLK_DIV);
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PCLK_DIV - 1);
    localparam logic [c_DW-1:0] c_DIV_HALF = c_DW'(PCLK_DIV / 2);

    logic [c_DW-1:0] r_div;
    logic [c_DW-1:0] w_div_nxt;
    logic            r_pclk;

    always_comb begin
        w_div_nxt = (r_div == c_DIV_LAST) ? '0 : r_div + c_DW'(1);
    end

    // PCLK is registered from the next count so it falls on the same edge
    // that the tick-driven outputs update.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_div  <= '0;
            r_pclk <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_pclk <= (w_div_nxt >= c_DIV_HALF);
        end
    end

    assign o_pclk = r_pclk;
    assign o_tick = (r_div == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/ov7670_dvp_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ov7670_dvp_source                                            |
// | Description : OV7670 DVP transmitter emitting raw-Bayer test frames.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ov7670_dvp_source
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int PCLK_DIV = DEF_PCLK_DIV
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [7:0]                 const_val,
    ov7670_dvp_source_if.master        dvp,
    output logic [7:0]                 frame_cnt,
    output logic                       frame_done
);

    localparam int              c_H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int              c_V_MAX   = max_int(max_int(V_SYNC, V_BACK), max_int(V_ACTIVE, V_FRONT));
    localparam int              c_HW      = cnt_width(c_H_TOTAL);
    localparam int              c_VW      = cnt_width(c_V_MAX);
    localparam logic [c_HW-1:0] c_H_LAST  = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT   = c_HW'(H_ACTIVE);

    logic            w_pclk;
    logic            w_tick;

    state_t          r_state,  w_state_nxt;
    logic [c_HW-1:0] r_hcnt,   w_hcnt_nxt;
    logic [c_VW-1:0] r_vcnt,   w_vcnt_nxt;
    logic [c_VW-1:0] w_lines_m1;
    logic [1:0]      r_pat,    w_pat_nxt;
    logic [7:0]      r_cval,   w_cval_nxt;
    logic [7:0]      r_fnum,   w_fnum_nxt;
    logic [7:0]      r_frame_cnt, w_frame_cnt_nxt;
    logic            r_frame_done;
    logic            w_frame_end;
    logic            w_start;
    logic            r_href,   w_href_nxt;
    logic            r_vsync,  w_vsync_nxt;
    logic [7:0]      r_d,      w_d_nxt;

    ov7670_pclk_gen #(
        .PCLK_DIV (PCLK_DIV)
    ) u_pclk_gen (
        .clk    (clk),
        .reset_ (reset_),
        .o_pclk (w_pclk),
        .o_tick (w_tick)
    );

    // Next pixel slot and the bus values that belong to it; all of it is
    // committed on the edge that ends a tick cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_vcnt_nxt  = r_vcnt;
        w_pat_nxt   = r_pat;
        w_cval_nxt  = r_cval;
        w_fnum_nxt  = r_fnum;
        w_frame_end = 1'b0;
        w_start     = 1'b0;
        w_lines_m1  = '0;

        case (r_state)
            SYNC:    w_lines_m1 = c_VW'(V_SYNC - 1);
            BACK:    w_lines_m1 = c_VW'(V_BACK - 1);
            ACTIVE:  w_lines_m1 = c_VW'(V_ACTIVE - 1);
            FRONT:   w_lines_m1 = c_VW'(V_FRONT - 1);
            default: w_lines_m1 = '0;
        endcase

        if (r_state == IDLE) begin
            w_start = enable;
        end else if (r_hcnt != c_H_LAST) begin
            w_hcnt_nxt = r_hcnt + c_HW'(1);
        end else begin
            w_hcnt_nxt = '0;
            if (r_vcnt != w_lines_m1) begin
                w_vcnt_nxt = r_vcnt + c_VW'(1);
            end else begin
                w_vcnt_nxt = '0;
                // Zero-line porches are skipped outright
                case (r_state)
                    SYNC:    w_state_nxt = (V_BACK > 0) ? BACK : ACTIVE;
                    BACK:    w_state_nxt = ACTIVE;
                    ACTIVE: begin
                        if (V_FRONT > 0) w_state_nxt = FRONT;
                        else             w_frame_end = 1'b1;
                    end
                    default: w_frame_end = 1'b1;
                endcase
            end
        end

        w_frame_cnt_nxt = r_frame_cnt + 8'(w_frame_end);

        if (w_frame_end) begin
            w_state_nxt = IDLE;
            w_start     = enable;
        end

        if (w_start) begin
            w_state_nxt = SYNC;
            w_hcnt_nxt  = '0;
            w_vcnt_nxt  = '0;
            w_pat_nxt   = pattern_sel;
            w_cval_nxt  = const_val;
            w_fnum_nxt  = w_frame_cnt_nxt;
        end

        w_vsync_nxt = (w_state_nxt == SYNC);
        w_href_nxt  = (w_state_nxt == ACTIVE) && (w_hcnt_nxt < c_H_ACT);
        w_d_nxt     = w_href_nxt ? pixel_value(w_pat_nxt, 8'(w_hcnt_nxt), 8'(w_vcnt_nxt),
                                               w_cval_nxt, w_fnum_nxt)
                                 : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state      <= IDLE;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_pat        <= PAT_RAMP;
            r_cval       <= 8'h00;
            r_fnum       <= 8'h00;
            r_frame_cnt  <= 8'h00;
            r_frame_done <= 1'b0;
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_d          <= 8'h00;
        end else begin
            r_frame_done <= w_tick & w_frame_end;
            if (w_tick) begin
                r_state     <= w_state_nxt;
                r_hcnt      <= w_hcnt_nxt;
                r_vcnt      <= w_vcnt_nxt;
                r_pat       <= w_pat_nxt;
                r_cval      <= w_cval_nxt;
                r_fnum      <= w_fnum_nxt;
                r_frame_cnt <= w_frame_cnt_nxt;
                r_href      <= w_href_nxt;
                r_vsync     <= w_vsync_nxt;
                r_d         <= w_d_nxt;
            end
        end
    end

    assign dvp.PCLK  = w_pclk;
    assign dvp.HREF  = r_href;
    assign dvp.VSYNC = r_vsync;
    assign dvp.D     = r_d;
    assign frame_cnt  = r_frame_cnt;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
